// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM receive demultiplexer with frame-alignment tracking
//
// Splits one round-robin sample stream of CHANNELS interleaved channels into
// per-channel held registers. Channel 0 of each frame is marked by in_sync.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   qualifies in_data / in_sync
//   in_data    multiplexed sample (WIDTH bits)
//   in_sync    sample is channel 0 of a frame
//   out_data   channel k held at [k*WIDTH +: WIDTH]
//   out_valid  one-cycle pulse per channel update (at most one bit set)
//   frame_done one-cycle pulse alongside the last channel's out_valid
//   locked     high while frame alignment is established
//   sync_err   one-cycle pulse on an early or missing sync
module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_sync,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    output logic                      frame_done,
    output logic                      locked,
    output logic                      sync_err
);

    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(CHANNELS - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [CHANNELS-1:0]       out_valid_q, out_valid_d;
    logic                      frame_done_q, frame_done_d;
    logic                      sync_err_q, sync_err_d;
    logic                      locked_q, locked_d;

    // Write request from the FSM; the write itself is decoded below so
    // the FSM only has to name the target slot.
    logic                      wr_en;
    logic [SW-1:0]             wr_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            data_q       <= '0;
            out_valid_q  <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            data_q       <= data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            locked_q     <= locked_d;
        end
    end

    // Next-state and alignment logic.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        wr_en        = 1'b0;
        wr_slot      = '0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Non-sync samples are silently dropped while hunting.
                    if (in_sync) begin
                        wr_en   = 1'b1;
                        wr_slot = '0;
                        slot_d  = SLOT_ONE;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sync) begin
                        // A sync anywhere but slot 0 is an early frame start:
                        // flag it, but trust the sync and realign on it.
                        sync_err_d = (slot_q != '0);
                        wr_en      = 1'b1;
                        wr_slot    = '0;
                        slot_d     = SLOT_ONE;
                    end else if (slot_q == '0) begin
                        // Expected a frame start and did not get one: alignment
                        // is lost, so drop the sample and go back to hunting.
                        sync_err_d = 1'b1;
                        slot_d     = '0;
                        state_d    = HUNT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_slot = slot_q;
                        // Explicit wrap so non-power-of-2 CHANNELS works.
                        if (slot_q == SLOT_LAST) begin
                            slot_d       = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            slot_d = slot_q + SLOT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // Channel register write decode.
    always_comb begin
        data_d      = data_q;
        out_valid_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (wr_en && (wr_slot == SW'(k))) begin
                data_d[k*WIDTH +: WIDTH] = in_data;
                out_valid_d[k]           = 1'b1;
            end
        end
    end

    assign out_data   = data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - table-driven scoreboard bench for tdm_demux
module tb_tdm_demux;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      in_valid = 1'b0;
    logic [WIDTH-1:0]          in_data = '0;
    logic                      in_sync = 1'b0;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic                      frame_done;
    logic                      locked;
    logic                      sync_err;

    tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sync    (in_sync),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic [3:0]  eov;
        logic        efd;
        logic        ese;
        logic        elk;
        logic [31:0] eod;
    } vec_t;

    typedef struct {
        int          id;
        logic [3:0]  eov;
        logic        efd;
        logic        ese;
        logic        elk;
        logic [31:0] eod;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic r, input logic v, input logic s, input logic [7:0] d,
                       input logic [3:0] eov, input logic efd, input logic ese,
                       input logic elk, input logic [31:0] eod);
        vec_t t;
        t.rst = r; t.v = v; t.s = s; t.d = d;
        t.eov = eov; t.efd = efd; t.ese = ese; t.elk = elk; t.eod = eod;
        vecs.push_back(t);
    endtask

    // Drive one cycle of stimulus, queue its expectation, and check the
    // registered result just after the edge that captures it.
    task automatic step(input int id, input vec_t t);
        exp_t e, g;
        rst      = t.rst;
        in_valid = t.v;
        in_sync  = t.s;
        in_data  = t.d;
        e.id = id; e.eov = t.eov; e.efd = t.efd; e.ese = t.ese; e.elk = t.elk; e.eod = t.eod;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        n_vec++;
        if (out_valid !== g.eov || frame_done !== g.efd || sync_err !== g.ese ||
            locked !== g.elk || out_data !== g.eod) begin
            n_miss++;
            $display("FAIL vec%0d: got ov=%b fd=%b se=%b lk=%b od=%h, expected ov=%b fd=%b se=%b lk=%b od=%h",
                     g.id, out_valid, frame_done, sync_err, locked, out_data,
                     g.eov, g.efd, g.ese, g.elk, g.eod);
        end
    endtask

    task automatic hand(input int id, input logic r, input logic v, input logic s,
                        input logic [7:0] d, input logic [3:0] eov, input logic efd,
                        input logic ese, input logic elk, input logic [31:0] eod);
        vec_t t;
        t.rst = r; t.v = v; t.s = s; t.d = d;
        t.eov = eov; t.efd = efd; t.ese = ese; t.elk = elk; t.eod = eod;
        step(id, t);
    endtask

    initial begin
        //   rst v  s  data   ov      fd    se    lk    out_data
        // Reset wins over a concurrent valid sync sample.
        add(1, 1, 1, 8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        // Basic frame.
        add(0, 1, 1, 8'hA0, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h000000A0);
        add(0, 1, 0, 8'hB1, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h0000B1A0);
        add(0, 1, 0, 8'hC2, 4'b0100, 1'b0, 1'b0, 1'b1, 32'h00C2B1A0);
        add(0, 1, 0, 8'hD3, 4'b1000, 1'b1, 1'b0, 1'b1, 32'hD3C2B1A0);
        // HUNT discards non-sync samples, then locks on sync.
        add(1, 0, 0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        add(0, 1, 0, 8'h01, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        add(0, 1, 0, 8'h02, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        add(0, 1, 0, 8'h03, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        add(0, 1, 0, 8'h04, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        add(0, 1, 0, 8'h05, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        add(0, 1, 1, 8'h11, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h00000011);
        add(0, 1, 0, 8'h22, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h00002211);
        add(0, 1, 0, 8'h33, 4'b0100, 1'b0, 1'b0, 1'b1, 32'h00332211);
        add(0, 1, 0, 8'h44, 4'b1000, 1'b1, 1'b0, 1'b1, 32'h44332211);
        // Early sync: resync into ch0, no frame_done for the short frame.
        add(0, 1, 1, 8'hA5, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h443322A5);
        add(0, 1, 0, 8'h5A, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h44335AA5);
        add(0, 1, 1, 8'h55, 4'b0001, 1'b0, 1'b1, 1'b1, 32'h44335A55);
        add(0, 1, 0, 8'h66, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h44336655);
        add(0, 1, 0, 8'h67, 4'b0100, 1'b0, 1'b0, 1'b1, 32'h44676655);
        add(0, 1, 0, 8'h68, 4'b1000, 1'b1, 1'b0, 1'b1, 32'h68676655);
        // Missing sync: error, sample dropped, back to HUNT.
        add(0, 1, 0, 8'h77, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h68676655);
        add(0, 0, 1, 8'hEE, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h68676655);
        add(0, 1, 0, 8'h78, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h68676655);
        // Frame with in_valid gaps; sync on an invalid cycle is ignored.
        add(0, 1, 1, 8'h10, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h68676610);
        add(0, 0, 0, 8'hEE, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h68676610);
        add(0, 0, 1, 8'hEE, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h68676610);
        add(0, 1, 0, 8'h20, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h68672010);
        add(0, 1, 0, 8'h30, 4'b0100, 1'b0, 1'b0, 1'b1, 32'h68302010);
        add(0, 0, 0, 8'hEE, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h68302010);
        add(0, 1, 0, 8'h40, 4'b1000, 1'b1, 1'b0, 1'b1, 32'h40302010);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i]);
        end

        // Reset mid-frame with a concurrent valid sample, then a clean frame.
        hand(100, 0, 1, 1, 8'h91, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h40302091);
        hand(101, 0, 1, 0, 8'h92, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h40309291);
        hand(102, 1, 1, 0, 8'h93, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000);
        hand(103, 0, 1, 1, 8'hB0, 4'b0001, 1'b0, 1'b0, 1'b1, 32'h000000B0);
        hand(104, 0, 1, 0, 8'hB1, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h0000B1B0);
        hand(105, 0, 1, 0, 8'hB2, 4'b0100, 1'b0, 1'b0, 1'b1, 32'h00B2B1B0);
        hand(106, 0, 1, 0, 8'hB3, 4'b1000, 1'b1, 1'b0, 1'b1, 32'hB3B2B1B0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
